// File: rtl/alu_defs.sv
// Shared encodings for the EX-stage ALU and multiply/divide unit.
package alu_defs;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_SRA  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Counter width able to hold the longer of the two latencies.
  function automatic int unsigned cnt_width(int unsigned mult_cyc, int unsigned div_cyc);
    int unsigned mx;
    mx = (mult_cyc > div_cyc) ? mult_cyc : div_cyc;
    return (mx < 2) ? 1 : $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/alu_md_unit_if.sv
// Operand/result bundle between the EX stage and the ALU + md unit.
interface alu_md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] C;
  logic             md_start;
  logic [2:0]       md_op;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output A, B, ALUOp, md_start, md_op,
    input  C, busy, hi, lo
  );

  modport slave (
    input  A, B, ALUOp, md_start, md_op,
    output C, busy, hi, lo
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU; unused opcodes produce zero.
module alu_core
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] c
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    c = '0;
    case (alu_op)
      ALU_ADD:  c = a + b;
      ALU_SUB:  c = a - b;
      ALU_AND:  c = a & b;
      ALU_OR:   c = a | b;
      ALU_SRL:  c = a >> shamt;
      ALU_SRA:  c = WIDTH'($signed(a) >>> shamt);
      ALU_SLL:  c = a << shamt;
      ALU_XOR:  c = a ^ b;
      ALU_NOR:  c = ~(a | b);
      ALU_SLT:  c = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: c = WIDTH'(a < b);
      default:  c = '0;
    endcase
  end

endmodule

// File: rtl/alu_md_unit.sv
// EX-stage execute block: combinational ALU plus multi-cycle mult/div with HI/LO.
module alu_md_unit
  import alu_defs::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  alu_md_unit_if.slave  bus
);

  localparam int unsigned CNT_W  = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam int unsigned PROD_W = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a      (bus.A),
    .b      (bus.B),
    .alu_op (bus.ALUOp),
    .c      (bus.C)
  );

  assign bus.busy = (state_q == ST_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Result datapath, evaluated from latched operands only.
  logic              is_mult, is_signed, a_neg, b_neg, div_by_zero;
  logic [PROD_W-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]  a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

  assign is_mult     = (op_q == MD_MULT) || (op_q == MD_MULTU);
  assign is_signed   = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign a_neg       = is_signed & a_q[WIDTH-1];
  assign b_neg       = is_signed & b_q[WIDTH-1];
  assign div_by_zero = (b_q == '0);

  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both mult and multu.
  assign a_ext = {{WIDTH{a_neg}}, a_q};
  assign b_ext = {{WIDTH{b_neg}}, b_q};
  assign prod  = a_ext * b_ext;

  // Magnitude divide then re-sign: truncation toward zero, remainder follows dividend.
  // MIN / -1 falls out naturally since |MIN| wraps back to MIN after negation.
  assign a_mag   = a_neg ? -a_q : a_q;
  assign b_mag   = b_neg ? -b_q : b_q;
  assign divisor = div_by_zero ? WIDTH'(1) : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem     = a_neg ? -r_mag : r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: accept in IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.md_start) begin
          case (bus.md_op)
            MD_MULT, MD_MULTU: begin
              op_d    = md_op_e'(bus.md_op);
              a_d     = bus.A;
              b_d     = bus.B;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              op_d    = md_op_e'(bus.md_op);
              a_d     = bus.A;
              b_d     = bus.B;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_RUN;
            end
            MD_MTHI: hi_d = bus.A;
            MD_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (is_mult) begin
            hi_d = prod[PROD_W-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (!div_by_zero) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
